// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the 3x3 (N x N) matrix-multiply sequencer:
//   - state_e       : sequencer FSM states
//   - *_BASE_DEF    : default byte base addresses of the A, B and C regions
//   - WORD_BYTES    : byte stride between consecutive matrix elements
//   - IDX_W         : width of the i/j/k loop indices (enough for N up to 4)
//   - elem_addr()   : row-major element byte-address helper
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [31:0] A_BASE_DEF = 32'h0000_0200;
    localparam logic [31:0] B_BASE_DEF = 32'h0000_0300;
    localparam logic [31:0] C_BASE_DEF = 32'h0000_0100;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int          IDX_W      = 3;

    // Byte address of element [row][col] of an n-column row-major matrix.
    function automatic logic [31:0] elem_addr(input logic [31:0]      base,
                                              input logic [IDX_W-1:0] row,
                                              input logic [IDX_W-1:0] col,
                                              input int               n);
        logic [31:0] idx;
        idx = 32'(row) * 32'(n) + 32'(col);
        return base + idx * WORD_BYTES;
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// -----------------------------------------------------------------------------
// matmul_sequencer_if
// Control handshake plus memory-master bus of the matmul sequencer.
//   start    : run request (host -> sequencer)
//   busy     : sequencer active (not IDLE)
//   done     : one-cycle completion pulse
//   memread  : memory read strobe
//   memwrite : memory write strobe
//   address  : memory byte address
//   data_in  : write data towards memory
//   data_out : combinational read data from memory
// modport master : the sequencer side; modport slave : memory/host side.
// -----------------------------------------------------------------------------
interface matmul_sequencer_if;

    logic        start;
    logic        busy;
    logic        done;
    logic        memread;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        input  start,
        input  data_out,
        output busy,
        output done,
        output memread,
        output memwrite,
        output address,
        output data_in
    );

    modport slave (
        output start,
        output data_out,
        input  busy,
        input  done,
        input  memread,
        input  memwrite,
        input  address,
        input  data_in
    );

endinterface

// File: rtl/matmul_addr_gen.sv
// -----------------------------------------------------------------------------
// matmul_addr_gen
// Combinational memory address generator for the matmul sequencer.
// Ports:
//   state_s   in  : current sequencer state
//   i_s, j_s, k_s in : row / column / inner loop indices
//   address_s out : A[i][k] in RD_A, B[k][j] in RD_B, C[i][j] in WR, else 0
// -----------------------------------------------------------------------------
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int          N      = 3,
    parameter logic [31:0] A_BASE = A_BASE_DEF,
    parameter logic [31:0] B_BASE = B_BASE_DEF,
    parameter logic [31:0] C_BASE = C_BASE_DEF
) (
    input  state_e           state_s,
    input  logic [IDX_W-1:0] i_s,
    input  logic [IDX_W-1:0] j_s,
    input  logic [IDX_W-1:0] k_s,
    output logic [31:0]      address_s
);

    // State-to-address decode; any state without a strobe drives 0.
    always_comb begin
        address_s = 32'd0;
        case (state_s)
            RD_A:    address_s = elem_addr(A_BASE, i_s, k_s, N);
            RD_B:    address_s = elem_addr(B_BASE, k_s, j_s, N);
            WR:      address_s = elem_addr(C_BASE, i_s, j_s, N);
            default: address_s = 32'd0;
        endcase
    end

endmodule

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
// Computes C = A x B (N x N, unsigned, modulo 2^32) by driving the main data
// memory directly: each C element takes N (read A, read B) pairs followed by
// one write. All bus outputs decode registered state, so they hold steady for
// the whole cycle and fall to 0 as soon as reset asserts.
// Ports:
//   clk   in : rising-edge clock
//   reset in : asynchronous active-high reset
//   bus       : matmul_sequencer_if.master (start/busy/done + memory bus)
// -----------------------------------------------------------------------------
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int          N      = 3,
    parameter logic [31:0] A_BASE = A_BASE_DEF,
    parameter logic [31:0] B_BASE = B_BASE_DEF,
    parameter logic [31:0] C_BASE = C_BASE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    matmul_sequencer_if.master bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [31:0]      a_reg_q, a_reg_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      prod_s;
    logic [31:0]      address_s;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_reg_q <= 32'd0;
            acc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_reg_q <= a_reg_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state, loop-index and multiply-accumulate logic.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_reg_d = a_reg_q;
        acc_d   = acc_q;
        // Low 32 bits of the product only; the accumulator simply wraps.
        prod_s  = a_reg_q * bus.data_out;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = 32'd0;
                    state_d = RD_A;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_A: begin
                a_reg_d = bus.data_out;
                state_d = RD_B;
            end
            RD_B: begin
                acc_d = acc_q + prod_s;
                if (k_q < LAST) begin
                    k_d     = k_q + ONE;
                    state_d = RD_A;
                end else begin
                    k_d     = '0;
                    state_d = WR;
                end
            end
            WR: begin
                acc_d = 32'd0;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d = '0;
                    end else begin
                        i_d = i_q + ONE;
                    end
                end else begin
                    j_d = j_q + ONE;
                end
                if ((i_q == LAST) && (j_q == LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    matmul_addr_gen #(
        .N      (N),
        .A_BASE (A_BASE),
        .B_BASE (B_BASE),
        .C_BASE (C_BASE)
    ) u_addr_gen (
        .state_s   (state_q),
        .i_s       (i_q),
        .j_s       (j_q),
        .k_s       (k_q),
        .address_s (address_s)
    );

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.memread  = (state_q == RD_A) || (state_q == RD_B);
    assign bus.memwrite = (state_q == WR);
    assign bus.address  = address_s;
    assign bus.data_in  = (state_q == WR) ? acc_q : 32'd0;

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;

    logic clk;
    logic reset;

    matmul_sequencer_if bus ();

    matmul_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: A and B regions readable, writes logged.
    logic [31:0] a_mem [0:15];
    logic [31:0] b_mem [0:15];
    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        if (bus.memread) begin
            if (bus.address >= 32'h200 && bus.address < 32'h240)
                rd_data = a_mem[bus.address[5:2]];
            else if (bus.address >= 32'h300 && bus.address < 32'h340)
                rd_data = b_mem[bus.address[5:2]];
            else
                rd_data = 32'd0;
        end else begin
            rd_data = 32'd0;
        end
    end
    assign bus.data_out = rd_data;

    logic [31:0] wlog_addr [0:127];
    logic [31:0] wlog_data [0:127];
    int wr_total = 0;
    always @(posedge clk) begin
        if (bus.memwrite) begin
            if (wr_total < 128) begin
                wlog_addr[wr_total] <= bus.address;
                wlog_data[wr_total] <= bus.data_in;
            end
            wr_total <= wr_total + 1;
        end
    end

    int both_cnt = 0;
    int strobe_viol = 0;
    always @(negedge clk) begin
        if (bus.memread && bus.memwrite) both_cnt <= both_cnt + 1;
        if ((!bus.memread && !bus.memwrite && bus.address != 32'd0) ||
            (!bus.memwrite && bus.data_in != 32'd0))
            strobe_viol <= strobe_viol + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-run observations.
    int          run_done_cyc;
    int          run_done_cnt;
    int          run_wr0;
    logic        bz      [0:100];
    logic        tr_rd   [1:7];
    logic        tr_wr   [1:7];
    logic [31:0] tr_addr [1:7];
    logic [31:0] exp_c   [0:8];

    // Pulse (or hold) start; observe 100 cycles; optional second start at restart_cyc.
    task automatic run(input int restart_cyc, input bit hold);
        run_done_cyc = 0;
        run_done_cnt = 0;
        run_wr0 = wr_total;
        bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            bz[c] = bus.busy;
            if (c <= 7) begin
                tr_rd[c]   = bus.memread;
                tr_wr[c]   = bus.memwrite;
                tr_addr[c] = bus.address;
            end
            if (bus.done) begin
                run_done_cnt++;
                if (run_done_cyc == 0) run_done_cyc = c;
            end
            if (c == restart_cyc) bus.start = 1'b1;
            else if (c == restart_cyc + 1 && !hold) bus.start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_c(input string name, input int base);
        for (int w = 0; w < 9; w++) begin
            check($sformatf("%s_addr%0d", name, w), wlog_addr[base + w], 32'h100 + 32'(w) * 32'd4);
            check($sformatf("%s_data%0d", name, w), wlog_data[base + w], exp_c[w]);
        end
    endtask

    task automatic check_run(input string name);
        check({name, "_done_cyc"}, 32'(run_done_cyc), 32'd64);
        check({name, "_done_cnt"}, 32'(run_done_cnt), 32'd1);
        check({name, "_writes"}, 32'(wr_total - run_wr0), 32'd9);
        check({name, "_busy64"}, {31'd0, bz[64]}, 32'd1);
        check({name, "_busy65"}, {31'd0, bz[65]}, 32'd0);
        check_c(name, run_wr0);
    endtask

    initial begin
        bus.start = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 16; n++) begin
            a_mem[n] = 32'd0;
            b_mem[n] = 32'd0;
        end
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_memread", {31'd0, bus.memread}, 32'd0);
        check("rst_memwrite", {31'd0, bus.memwrite}, 32'd0);
        check("rst_address", bus.address, 32'd0);
        check("rst_data_in", bus.data_in, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Identity: A = 1..9, B = I
        for (int n = 0; n < 9; n++) begin
            a_mem[n] = 32'(n + 1);
            b_mem[n] = (n % 4 == 0) ? 32'd1 : 32'd0;
            exp_c[n] = 32'(n + 1);
        end
        run(0, 1'b0);
        check_run("ident");
        // Address trace of the first element
        check("tr1", {tr_rd[1], tr_wr[1], tr_addr[1]}, {2'b10, 32'h200});
        check("tr2", {tr_rd[2], tr_wr[2], tr_addr[2]}, {2'b10, 32'h300});
        check("tr3", {tr_rd[3], tr_wr[3], tr_addr[3]}, {2'b10, 32'h204});
        check("tr4", {tr_rd[4], tr_wr[4], tr_addr[4]}, {2'b10, 32'h30C});
        check("tr5", {tr_rd[5], tr_wr[5], tr_addr[5]}, {2'b10, 32'h208});
        check("tr6", {tr_rd[6], tr_wr[6], tr_addr[6]}, {2'b10, 32'h318});
        check("tr7", {tr_rd[7], tr_wr[7], tr_addr[7]}, {2'b01, 32'h100});

        // All-twos B
        for (int n = 0; n < 9; n++) b_mem[n] = 32'd2;
        exp_c[0] = 32'd12; exp_c[1] = 32'd12; exp_c[2] = 32'd12;
        exp_c[3] = 32'd30; exp_c[4] = 32'd30; exp_c[5] = 32'd30;
        exp_c[6] = 32'd48; exp_c[7] = 32'd48; exp_c[8] = 32'd48;
        run(0, 1'b0);
        check_run("twos");

        // Wrap: row 0 of A = 0x8000_0000 -> 3 * 2^32 wraps to 0
        a_mem[0] = 32'h8000_0000; a_mem[1] = 32'h8000_0000; a_mem[2] = 32'h8000_0000;
        exp_c[0] = 32'd0; exp_c[1] = 32'd0; exp_c[2] = 32'd0;
        run(0, 1'b0);
        check_run("wrap");

        // Start while busy is ignored
        a_mem[0] = 32'd1; a_mem[1] = 32'd2; a_mem[2] = 32'd3;
        exp_c[0] = 32'd12; exp_c[1] = 32'd12; exp_c[2] = 32'd12;
        run(10, 1'b0);
        check_run("restart");
        check("restart_no_rerun", {31'd0, bz[80]}, 32'd0);

        // Mid-run reset at cycle 20
        run_wr0 = wr_total;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_memread", {31'd0, bus.memread}, 32'd0);
        check("mid_memwrite", {31'd0, bus.memwrite}, 32'd0);
        check("mid_address", bus.address, 32'd0);
        check("mid_data_in", bus.data_in, 32'd0);
        check("mid_partial_writes", 32'(wr_total - run_wr0), 32'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {31'd0, bus.busy}, 32'd0);
        for (int n = 0; n < 9; n++) b_mem[n] = (n % 4 == 0) ? 32'd1 : 32'd0;
        for (int n = 0; n < 9; n++) exp_c[n] = 32'(n + 1);
        run(0, 1'b0);
        check_run("after_rst");

        // Start held high through DONE relaunches from IDLE
        run(0, 1'b1);
        check("hold_done_cyc", 32'(run_done_cyc), 32'd64);
        check("hold_busy65", {31'd0, bz[65]}, 32'd0);
        check("hold_busy66", {31'd0, bz[66]}, 32'd1);
        bus.start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        check("never_rd_and_wr", 32'(both_cnt), 32'd0);
        check("zero_when_no_strobe", 32'(strobe_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Hardware sequencer that computes the 3×3 product C = A × B using the main data memory. It drives the memory's read/write/address/data ports directly: it fetches A and B elements from their fixed regions, multiplies and accumulates internally, and writes each C element back. It sits beside the CPU datapath as a second memory master; the top level muxes the memory ports to the sequencer while `busy` is high.

## Interface
Parameters:
- `N`, 3: matrix dimension; supported values are 2–4.
- `A_BASE`, 32'h0000_0200: byte address of A[0][0], row-major, 4-byte stride.
- `B_BASE`, 32'h0000_0300: byte address of B[0][0], row-major, 4-byte stride.
- `C_BASE`, 32'h0000_0100: byte address of C[0][0], row-major, 4-byte stride.

Ports (one clock; `reset` is asynchronous, active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  async active-high reset.
- `start`  in  1  request one multiplication; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last C element has been written.
- `memread`  out  1  memory read strobe.
- `memwrite`  out  1  memory write strobe.
- `address`  out  32  memory byte address.
- `data_in`  out  32  write data to memory.
- `data_out`  in  32  combinational read data from memory; valid in the same cycle as `memread`/`address`.

## Operation
- Internal state: FSM, row index `i`, column index `j`, inner index `k` (each 0..N-1), 32-bit `a_reg`, 32-bit accumulator `acc`.
- FSM states:
  - **IDLE**: all memory outputs are 0. If `start`=1: clear `i`, `j`, `k`, `acc`, then go to RD_A.
  - **RD_A**: `memread`=1, `address` = A_BASE + 4·(i·N+k). Latch `data_out` into `a_reg`. Go to RD_B.
  - **RD_B**: `memread`=1, `address` = B_BASE + 4·(k·N+j). Set `acc` ← `acc` + `a_reg`·`data_out`.
    - If k<N-1: increment `k`, go to RD_A.
    - Otherwise clear `k` and go to WR.
  - **WR**: `memwrite`=1, `address` = C_BASE + 4·(i·N+j), `data_in` = `acc`. Clear `acc`.
    - Advance `j`; when `j` wraps, advance `i`.
    - If i=N-1 and j=N-1: go to DONE. Otherwise go to RD_A.
  - **DONE**: `done`=1 for exactly one cycle; go to IDLE.
- Arithmetic: unsigned. Each product is truncated to its low 32 bits, and the accumulation wraps modulo 2^32. No overflow flag.
- `memread` and `memwrite` are never high together. `address` and `data_in` are 0 whenever their strobe is low.
- `start` asserted while `busy` is ignored; it is not queued.
- `start` held high through DONE launches a new run from IDLE on the following cycle.

## Timing
- Reset values: FSM=IDLE; `busy`, `done`, `memread`, `memwrite`, `address`, `data_in`, `acc`, `a_reg`, `i`, `j`, `k` are all 0.
- All memory-port outputs are registered-state decodes and are stable for the whole cycle.
- Per C element: 2N read cycles followed by 1 write cycle. For N=3 that is 7 cycles per element and 63 cycles per run.
- Cycle numbering (start sampled at edge 0):
  - Cycles 1–63: RD/WR activity.
  - Cycle 64: DONE.
  - Cycle 65: IDLE.
  - `busy` is high in cycles 1–64.
- Reset asserted mid-run: FSM returns to IDLE immediately, with no further memory strobes. C elements already written stay in memory. The next `start` after reset deasserts recomputes every element from scratch.
- Write element order is (0,0), (0,1), …, (N-1,N-1).

## Structure
- Package `matmul_pkg`: FSM state enum (IDLE, RD_A, RD_B, WR, DONE), default base-address constants, and the `WORD_BYTES`=4 constant.
- One sub-module, `matmul_addr_gen`: combinational map from (state, i, j, k) to `address`, using the base parameters.
- The MAC and FSM stay in the top module.

## Test plan
- **Identity**: A=1..9, B=identity, pulse `start` → C region holds 1..9; `done` pulses at cycle 64; exactly 9 writes observed.
- **All-twos B**: A=1..9, B=all 2s → C = {12,12,12, 30,30,30, 48,48,48}.
- **Address trace**: check the first 7 cycles are reads 0x200, 0x300, 0x204, 0x30C, 0x208, 0x318, then write 0x100. Check `memread` and `memwrite` are never both high.
- **Wrap**: A[0][*]=32'h8000_0000, B=all 2s → C[0][*]=0, which confirms modulo-2^32 accumulation.
- **Start while busy**: pulse `start` again at cycle 10 → run still ends at cycle 64 with a single `done`; no second run follows.
- **Mid-run reset**: assert `reset` at cycle 20 → all outputs are 0 in the same cycle; after release plus `start`, the full correct C is produced and `done` pulses at cycle 64 relative to the new start.
